// File: rtl/sequence_checker.sv
// Sequence checker: compares strobed player symbols against a latched
// expected sequence, with optional per-step idle timeout.
module sequence_checker #(
  parameter int DIR_W   = 2,
  parameter int MAX_LEN = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 0
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [IDX_W:0]           length,
  input  logic [MAX_LEN*DIR_W-1:0] sequence_bits,
  input  logic                     dir_valid,
  input  logic [DIR_W-1:0]         direction,
  output logic                     busy,
  output logic [IDX_W-1:0]         step_idx,
  output logic                     step_ok,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W:0] LMAX = (IDX_W + 1)'(MAX_LEN);
  localparam logic [IDX_W:0] LONE = (IDX_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t state, state_n;

  logic [MAX_LEN*DIR_W-1:0] seq_q, seq_n;
  logic [IDX_W:0]           len_q, len_n;
  logic [TW-1:0]            timer_q, timer_n;
  logic [IDX_W-1:0]         idx_n;
  logic                     busy_n, ok_n, done_n;
  logic                     pass_n, fail_n, to_n;

  logic [DIR_W-1:0] syms [MAX_LEN];
  logic [DIR_W-1:0] expect_sym;
  logic             last;

  // Step 0 lives in the most significant symbol slot.
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++)
      syms[i] = seq_q[(MAX_LEN-1-i)*DIR_W +: DIR_W];
  end

  assign expect_sym = syms[step_idx];
  assign last = ({1'b0, step_idx} == (len_q - LONE));

  always_comb begin
    state_n = state;
    seq_n   = seq_q;
    len_n   = len_q;
    idx_n   = step_idx;
    timer_n = timer_q;
    ok_n    = 1'b0;
    done_n  = 1'b0;
    pass_n  = pass;
    fail_n  = fail;
    to_n    = timeout;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          seq_n   = sequence_bits;
          len_n   = (length == '0 || length > LMAX) ? LMAX : length;
          idx_n   = '0;
          timer_n = '0;
          pass_n  = 1'b0;
          fail_n  = 1'b0;
          to_n    = 1'b0;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (dir_valid) begin
          timer_n = '0;
          if (direction == expect_sym) begin
            ok_n = 1'b1;
            if (last) begin
              pass_n  = 1'b1;
              done_n  = 1'b1;
              idx_n   = '0;
              state_n = DONE;
            end else begin
              idx_n = step_idx + IDX_W'(1);
            end
          end else begin
            fail_n  = 1'b1;
            done_n  = 1'b1;
            state_n = DONE;
          end
        end else if (TIMEOUT != 0) begin
          timer_n = timer_q + TW'(1);
          if (timer_q == TMAX) begin
            fail_n  = 1'b1;
            to_n    = 1'b1;
            done_n  = 1'b1;
            state_n = DONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == CHECK);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      seq_q    <= '0;
      len_q    <= '0;
      timer_q  <= '0;
      step_idx <= '0;
      busy     <= 1'b0;
      step_ok  <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      seq_q    <= seq_n;
      len_q    <= len_n;
      timer_q  <= timer_n;
      step_idx <= idx_n;
      busy     <= busy_n;
      step_ok  <= ok_n;
      done     <= done_n;
      pass     <= pass_n;
      fail     <= fail_n;
      timeout  <= to_n;
    end
  end

endmodule

// File: tb/tb_sequence_checker.sv
// Directed vector bench for sequence_checker.
module tb_sequence_checker;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [3:0]  length;
  logic [15:0] sequence_bits;
  logic        dir_valid;
  logic [1:0]  direction;
  logic        busy;
  logic [2:0]  step_idx;
  logic        step_ok;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  sequence_checker #(
    .DIR_W(2), .MAX_LEN(8), .IDX_W(3), .TIMEOUT(16)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .start(start),
    .length(length),
    .sequence_bits(sequence_bits),
    .dir_valid(dir_valid),
    .direction(direction),
    .busy(busy),
    .step_idx(step_idx),
    .step_ok(step_ok),
    .done(done),
    .pass(pass),
    .fail(fail),
    .timeout(timeout)
  );

  typedef struct {
    logic        rstn;
    logic        st;
    logic [3:0]  len;
    logic [15:0] seq;
    logic        dv;
    logic [1:0]  dir;
    logic [8:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string name, input logic rstn, input logic st,
    input logic [3:0] len, input logic [15:0] seq,
    input logic dv, input logic [1:0] dir,
    input logic b, input logic [2:0] idx, input logic ok,
    input logic dn, input logic ps, input logic fl,
    input logic to);
    vec_t v;
    v.name = name; v.rstn = rstn; v.st = st; v.len = len;
    v.seq = seq; v.dv = dv; v.dir = dir;
    v.exp = {b, idx, ok, dn, ps, fl, to};
    return v;
  endfunction

  // Drive on the falling edge, check 1 time unit after the rising edge.
  task automatic cycle(
    input string name, input logic rstn, input logic st,
    input logic [3:0] len, input logic [15:0] seq,
    input logic dv, input logic [1:0] dir, input logic [8:0] exp);
    logic [8:0] got;
    @(negedge clock);
    resetn = rstn; start = st; length = len;
    sequence_bits = seq; dir_valid = dv; direction = dir;
    @(posedge clock);
    #1;
    got = {busy, step_idx, step_ok, done, pass, fail, timeout};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got busy/idx/ok/done/pass/fail/to=%b required %b",
               name, got, exp);
    end
    if (pass && fail) begin
      errors++;
      $display("FAIL %s: pass and fail both high", name);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; length = '0;
    sequence_bits = '0; dir_valid = 1'b0; direction = '0;

    //              name       rn st len seq      dv dir  b idx ok dn ps fl to
    vecs.push_back(mk("rst0",   0, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rst1",   0, 1, 4, 16'h9C00, 1, 2,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("p_st",   1, 1, 4, 16'h9C00, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("p_d0",   1, 0, 0, 16'h0000, 1, 2,  1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("p_d1",   1, 0, 0, 16'h0000, 1, 1,  1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk("p_gap",  1, 0, 0, 16'h0000, 0, 0,  1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("p_d2",   1, 0, 0, 16'h0000, 1, 3,  1, 3, 1, 0, 0, 0, 0));
    vecs.push_back(mk("p_d3",   1, 0, 0, 16'h0000, 1, 0,  0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk("p_hold", 1, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("p_ign",  1, 0, 0, 16'h0000, 1, 2,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("f_st",   1, 1, 4, 16'h9C00, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("f_d0",   1, 0, 0, 16'h0000, 1, 2,  1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("f_bad",  1, 0, 0, 16'h0000, 1, 3,  0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk("f_hold", 1, 0, 0, 16'h0000, 0, 0,  0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk("a_st",   1, 1, 4, 16'h9C00, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("a_d0",   1, 0, 0, 16'h0000, 1, 2,  1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("a_d1",   1, 0, 0, 16'h0000, 1, 1,  1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk("a_rst",  0, 0, 0, 16'h0000, 1, 3,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("a_ign",  1, 0, 0, 16'h0000, 1, 2,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("c_st",   1, 1, 0, 16'hFFFF, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("c_d0",   1, 0, 0, 16'h0000, 1, 3,  1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("c_d1",   1, 0, 0, 16'h0000, 1, 3,  1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk("c_busy", 1, 1, 2, 16'h0000, 1, 3,  1, 3, 1, 0, 0, 0, 0));
    vecs.push_back(mk("c_d3",   1, 0, 0, 16'h0000, 1, 3,  1, 4, 1, 0, 0, 0, 0));
    vecs.push_back(mk("c_d4",   1, 0, 0, 16'h0000, 1, 3,  1, 5, 1, 0, 0, 0, 0));
    vecs.push_back(mk("c_d5",   1, 0, 0, 16'h0000, 1, 3,  1, 6, 1, 0, 0, 0, 0));
    vecs.push_back(mk("c_d6",   1, 0, 0, 16'h0000, 1, 3,  1, 7, 1, 0, 0, 0, 0));
    vecs.push_back(mk("c_d7",   1, 0, 0, 16'h0000, 1, 3,  0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk("l_st",   1, 1, 12, 16'h9C00, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("l_d0",   1, 0, 0, 16'h0000, 1, 2,  1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("l_d1",   1, 0, 0, 16'h0000, 1, 1,  1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk("l_d2",   1, 0, 0, 16'h0000, 1, 3,  1, 3, 1, 0, 0, 0, 0));
    vecs.push_back(mk("l_d3",   1, 0, 0, 16'h0000, 1, 0,  1, 4, 1, 0, 0, 0, 0));

    foreach (vecs[i])
      cycle(vecs[i].name, vecs[i].rstn, vecs[i].st, vecs[i].len,
            vecs[i].seq, vecs[i].dv, vecs[i].dir, vecs[i].exp);

    // Timeout: 16 idle CHECK cycles expire the step.
    cycle("t_rst", 0, 0, 0, 16'h0, 0, 0, 9'b0_000_0000_0);
    cycle("t_st", 1, 1, 4, 16'h9C00, 0, 0, 9'b1_000_0000_0);
    for (int k = 1; k < 16; k++)
      cycle("t_wait", 1, 0, 0, 16'h0, 0, 0, 9'b1_000_0000_0);
    cycle("t_exp", 1, 0, 0, 16'h0, 0, 0, 9'b0_000_0101_1);
    cycle("t_hold", 1, 0, 0, 16'h0, 0, 0, 9'b0_000_0001_1);

    // dir_valid on the expiring cycle wins over the timeout.
    cycle("t2_st", 1, 1, 4, 16'h9C00, 0, 0, 9'b1_000_0000_0);
    for (int k = 1; k < 16; k++)
      cycle("t2_wait", 1, 0, 0, 16'h0, 0, 0, 9'b1_000_0000_0);
    cycle("t2_hit", 1, 0, 0, 16'h0, 1, 2, 9'b1_001_1000_0);
    for (int k = 1; k < 16; k++)
      cycle("t2_rearm", 1, 0, 0, 16'h0, 0, 0, 9'b1_001_0000_0);
    cycle("t2_exp", 1, 0, 0, 16'h0, 0, 0, 9'b0_001_0101_1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
